// File: rtl/tb_arbiter.sv
// tb_arbiter: round-robin arbiter sharing one single-port RAM between two requesters
module tb_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic          last_q, last_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          s1_v_q, s1_v_d, s1_p_q, s1_p_d;
  logic          s2_v_q, s2_p_q;
  logic          xfer, win_we;
  // lone requester wins; on a tie the port that did not win last goes first
  always_comb begin
    p0_gnt  = ~rst & p0_req & (~p1_req | last_q);
    p1_gnt  = ~rst & p1_req & (~p0_req | ~last_q);
    xfer    = p0_gnt | p1_gnt;
    win_we  = p1_gnt ? p1_we : p0_we;
    last_d  = xfer ? p1_gnt : last_q;
    wen_d   = xfer & win_we;
    addr_d  = xfer ? (p1_gnt ? p1_addr : p0_addr) : addr_q;
    wdata_d = xfer ? (p1_gnt ? p1_wdata : p0_wdata) : wdata_q;
    s1_v_d  = xfer & ~win_we;
    s1_p_d  = p1_gnt;
  end
  // RAM controls and the two-stage read tag pipeline; reset drops in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      s1_v_q  <= 1'b0;
      s1_p_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      s2_p_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      s1_v_q  <= s1_v_d;
      s1_p_q  <= s1_p_d;
      s2_v_q  <= s1_v_q;
      s2_p_q  <= s1_p_q;
    end
  end
  assign mem_wen   = wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = mem_rdata;
  assign p0_rvalid = s2_v_q & ~s2_p_q;
  assign p1_rvalid = s2_v_q & s2_p_q;
endmodule

// File: tb/tb_tb_arbiter.sv
// tb_tb_arbiter: randomized and directed checks of tb_arbiter against a shadow-memory response model
module tb_tb_arbiter;
  logic clk = 0, rst = 1;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [9:0] p0_addr = 0, p1_addr = 0, mem_addr;
  logic [7:0] p0_wdata = 0, p1_wdata = 0, rdata, mem_wdata, mem_rdata;
  logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_wen;
  typedef struct {bit req; bit we; logic [9:0] a; logic [7:0] d;} rq_t;
  typedef struct {bit p; logic [7:0] d; int c;} ev_t;
  rq_t q0[$], q1[$];
  ev_t exp_q[$], rlog[$], glog[$];
  logic [7:0] ram [1024];
  logic [7:0] shadow [1024];
  int cyc = 0, tot = 0, pass = 0, wen_cnt = 0;
  bit g0, g1, e0, e1, ev, ep, wwe, m_last1 = 1, m_wen = 0;
  logic [9:0] m_addr = 0, wa;
  logic [7:0] m_wdata = 0, wd;

  tb_arbiter #(.AW(10), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] f(int i);
    logic [9:0] a;
    a = i[9:0];
    return a[7:0] ^ {a[9:8], 6'b0};
  endfunction

  // RAM with registered read; contents return to the preload pattern during reset
  always @(posedge clk)
    if (rst) for (int i = 0; i < 1024; i++) ram[i] <= f(i);
    else begin
      if (mem_wen) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
  endfunction

  function automatic int gport(int i); return i < glog.size() ? int'(glog[i].p) : -1; endfunction
  function automatic int gcyc(int i);  return i < glog.size() ? glog[i].c : -1000; endfunction
  function automatic int rport(int i); return i < rlog.size() ? int'(rlog[i].p) : -1; endfunction
  function automatic int rdat(int i);  return i < rlog.size() ? int'(rlog[i].d) : -1; endfunction
  function automatic int rcyc(int i);  return i < rlog.size() ? rlog[i].c : -1000; endfunction

  // model: shadow memory updated in grant order, reads answered 2 cycles after their grant cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_last1 = 1; m_wen = 0; m_addr = 0; m_wdata = 0; g0 = 0; g1 = 0;
      for (int i = 0; i < 1024; i++) shadow[i] = f(i);
      chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
      chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
    end else begin
      e0 = p0_req && (!p1_req || m_last1);
      e1 = p1_req && !e0;
      chk("gnt0", p0_gnt, e0);
      chk("gnt1", p1_gnt, e1);
      chk("mem_wen", mem_wen, m_wen);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      if (mem_wen) wen_cnt++;
      ev = exp_q.size() > 0 && exp_q[0].c == cyc;
      ep = ev ? exp_q[0].p : 1'b0;
      chk("rvalid0", p0_rvalid, ev && !ep);
      chk("rvalid1", p1_rvalid, ev && ep);
      if (p0_rvalid || p1_rvalid) rlog.push_back('{p1_rvalid, rdata, cyc});
      if (ev) begin
        chk("rdata", rdata, exp_q[0].d);
        void'(exp_q.pop_front());
      end
      if (e0 || e1) begin
        wa = e1 ? p1_addr : p0_addr;
        wwe = e1 ? p1_we : p0_we;
        wd = e1 ? p1_wdata : p0_wdata;
        if (wwe) shadow[wa] = wd;
        else exp_q.push_back('{e1, shadow[wa], cyc + 2});
        glog.push_back('{e1, 8'h0, cyc});
        m_last1 = e1; m_wen = wwe; m_addr = wa; m_wdata = wd;
      end else m_wen = 0;
      g0 = p0_gnt && p0_req;
      g1 = p1_gnt && p1_req;
    end
  end

  function automatic void push(int p, bit req, bit we, int a, int d);
    rq_t r;
    r.req = req; r.we = we; r.a = a[9:0]; r.d = d[7:0];
    if (p == 0) q0.push_back(r); else q1.push_back(r);
  endfunction
  function automatic void rd(int p, int a); push(p, 1, 0, a, 0); endfunction
  function automatic void wr(int p, int a, int d); push(p, 1, 1, a, d); endfunction

  task automatic step();
    rq_t r;
    @(posedge clk); #1;
    if (!p0_req || g0) begin
      if (q0.size() > 0) begin
        r = q0.pop_front();
        p0_req = r.req; p0_we = r.we; p0_addr = r.a; p0_wdata = r.d;
      end else p0_req = 0;
    end
    if (!p1_req || g1) begin
      if (q1.size() > 0) begin
        r = q1.pop_front();
        p1_req = r.req; p1_we = r.we; p1_addr = r.a; p1_wdata = r.d;
      end else p1_req = 0;
    end
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || p0_req || p1_req || exp_q.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      tot++;
      $display("FAIL drain_timeout: got %0d cycles without completion, expected fewer than %0d", n, maxc);
    end
  endtask

  task automatic clear_logs();
    rlog.delete(); glog.delete(); wen_cnt = 0;
  endtask

  initial begin
    logic [7:0] ce [6];
    int bad;
    ce = '{8'h00, 8'h40, 8'h01, 8'h41, 8'h02, 8'h42};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // reset with a read response and a write both in flight
    rd(0, 'h10); wr(1, 'h12, 'h77);
    repeat (3) step();
    chk("pre_rst_rvalid0", p0_rvalid, 1);
    chk("pre_rst_wen", mem_wen, 1);
    rst = 1;
    q0.delete(); q1.delete(); p0_req = 0; p1_req = 0;
    clear_logs();
    #1;
    chk("async_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("async_wen", mem_wen, 0);
    repeat (2) step();
    rst = 0;
    repeat (5) step();
    chk("no_rvalid_after_rst", rlog.size(), 0);
    rd(0, 'h20); rd(1, 'h21);
    drain(50);
    chk("tie_first_p0", gport(0), 0);
    chk("tie_second_p1", gport(1), 1);
    chk("tie_data0", rdat(0), 'h20);
    chk("tie_data1", rdat(1), 'h21);
    // single write then read on p1
    clear_logs();
    wr(1, 'h28, 'h41); rd(1, 'h28);
    drain(50);
    chk("wr_rd_count", rlog.size(), 1);
    chk("wr_rd_port", rport(0), 1);
    chk("wr_rd_data", rdat(0), 'h41);
    chk("wr_rd_wen_cycles", wen_cnt, 1);
    chk("wr_rd_latency", rcyc(0) - gcyc(1), 2);
    // contention: alternating grants
    clear_logs();
    for (int i = 0; i < 3; i++) begin rd(0, i); rd(1, 'h100 + i); end
    drain(50);
    for (int i = 0; i < 6; i++) begin
      chk("cont_gnt", gport(i), i % 2);
      chk("cont_rport", rport(i), i % 2);
      chk("cont_rdata", rdat(i), ce[i]);
    end
    // mixed read and write to the same address
    clear_logs();
    rd(0, 'h3ff); wr(1, 'h3ff, 'h5a); rd(1, 'h3ff);
    drain(50);
    chk("mix_gnt0", gport(0), 0);
    chk("mix_gnt1", gport(1), 1);
    chk("mix_gnt2", gport(2), 1);
    chk("mix_old", rdat(0), 'h3f);
    chk("mix_old_port", rport(0), 0);
    chk("mix_new", rdat(1), 'h5a);
    chk("mix_new_port", rport(1), 1);
    // full-address burst on p0
    clear_logs();
    for (int i = 0; i < 1024; i++) rd(0, i);
    drain(1200);
    chk("burst_rcount", rlog.size(), 1024);
    chk("burst_gcount", glog.size(), 1024);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (rcyc(i) != rcyc(0) + i || rport(i) != 0 || gcyc(i) != gcyc(0) + i) bad++;
    chk("burst_contig", bad, 0);
    chk("burst_last_lat", rcyc(1023) - gcyc(1023), 2);
    chk("burst_last_data", rdat(1023), 'h5a);
    chk("burst_28", rdat('h28), 'h41);
    chk("burst_155", rdat('h155), 'h15);
    // idle
    clear_logs();
    repeat (10) step();
    chk("idle_addr", mem_addr, 'h3ff);
    chk("idle_wen", wen_cnt, 0);
    chk("idle_rvalid", rlog.size(), 0);
    chk("idle_gnt", glog.size(), 0);
    // randomized traffic
    for (int n = 0; n < 1500; n++)
      for (int p = 0; p < 2; p++) begin
        int r, a;
        r = $urandom_range(0, 3);
        a = $urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
        if (r == 0) push(p, 0, 0, 0, 0);
        else if (r == 1) wr(p, a, $urandom_range(0, 255));
        else rd(p, a);
      end
    drain(20000);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
